// File: rtl/hahaha.sv
// rtl/hahaha.sv - single-cycle mini-MIPS execute core with GPRs, HI/LO and word-addressed data memory
// Optional multiply-accumulate ops (madd/maddu) enabled by defining HAHAHA_MADD_EN.
module hahaha #(
    parameter int DMEM_WORDS     = 256,
    parameter int GPR_INIT_INDEX = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int AW = $clog2(DMEM_WORDS);

    logic [31:0] r_gpr [32];
    logic [31:0] r_dmem [DMEM_WORDS];
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_sh;
    logic [5:0]  w_fn;
    logic [15:0] w_imm;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_simm;
    logic [31:0] w_zimm;
    logic [31:0] w_addr;
    logic [AW-1:0] w_mem_idx;
    logic        w_unused_addr;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    logic        w_gpr_we;
    logic [4:0]  w_gpr_waddr;
    logic [31:0] w_gpr_wdata;
    logic        w_hilo_we;
    logic [63:0] w_hilo_next;
    logic        w_mem_we;

    assign w_op     = instruction[31:26];
    assign w_rs     = instruction[25:21];
    assign w_rt     = instruction[20:16];
    assign w_rd     = instruction[15:11];
    assign w_sh     = instruction[10:6];
    assign w_fn     = instruction[5:0];
    assign w_imm    = instruction[15:0];
    assign w_rs_val = r_gpr[w_rs];
    assign w_rt_val = r_gpr[w_rt];
    assign w_simm   = {{16{w_imm[15]}}, w_imm};
    assign w_zimm   = {16'h0000, w_imm};

    // Byte address: low two bits dropped, high bits wrap modulo the memory size.
    assign w_addr        = w_rs_val + w_simm;
    assign w_mem_idx     = w_addr[AW+1:2];
    assign w_unused_addr = ^{w_addr[31:AW+2], w_addr[1:0]};

    assign w_prod_s = $signed({{32{w_rs_val[31]}}, w_rs_val}) * $signed({{32{w_rt_val[31]}}, w_rt_val});
    assign w_prod_u = {32'h0, w_rs_val} * {32'h0, w_rt_val};

    always_comb begin
        w_gpr_we    = 1'b0;
        w_gpr_waddr = w_rt;
        w_gpr_wdata = 32'h0;
        w_hilo_we   = 1'b0;
        w_hilo_next = {r_hi, r_lo};
        w_mem_we    = 1'b0;
        case (w_op)
            6'h00: begin
                w_gpr_waddr = w_rd;
                w_gpr_we    = 1'b1;
                case (w_fn)
                    6'h20, 6'h21: w_gpr_wdata = w_rs_val + w_rt_val;
                    6'h22, 6'h23: w_gpr_wdata = w_rs_val - w_rt_val;
                    6'h24:        w_gpr_wdata = w_rs_val & w_rt_val;
                    6'h25:        w_gpr_wdata = w_rs_val | w_rt_val;
                    6'h26:        w_gpr_wdata = w_rs_val ^ w_rt_val;
                    6'h27:        w_gpr_wdata = ~(w_rs_val | w_rt_val);
                    6'h2A:        w_gpr_wdata = {31'h0, $signed(w_rs_val) < $signed(w_rt_val)};
                    6'h2B:        w_gpr_wdata = {31'h0, w_rs_val < w_rt_val};
                    6'h00:        w_gpr_wdata = w_rt_val << w_sh;
                    6'h02:        w_gpr_wdata = w_rt_val >> w_sh;
                    6'h03:        w_gpr_wdata = $signed(w_rt_val) >>> w_sh;
                    6'h10:        w_gpr_wdata = r_hi;
                    6'h12:        w_gpr_wdata = r_lo;
                    6'h18: begin
                        w_gpr_we    = 1'b0;
                        w_hilo_we   = 1'b1;
                        w_hilo_next = w_prod_s;
                    end
                    6'h19: begin
                        w_gpr_we    = 1'b0;
                        w_hilo_we   = 1'b1;
                        w_hilo_next = w_prod_u;
                    end
                    default:      w_gpr_we = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin
                w_gpr_we    = 1'b1;
                w_gpr_wdata = w_rs_val + w_simm;
            end
            6'h0A: begin
                w_gpr_we    = 1'b1;
                w_gpr_wdata = {31'h0, $signed(w_rs_val) < $signed(w_simm)};
            end
            6'h0C: begin
                w_gpr_we    = 1'b1;
                w_gpr_wdata = w_rs_val & w_zimm;
            end
            6'h0D: begin
                w_gpr_we    = 1'b1;
                w_gpr_wdata = w_rs_val | w_zimm;
            end
            6'h0E: begin
                w_gpr_we    = 1'b1;
                w_gpr_wdata = w_rs_val ^ w_zimm;
            end
            6'h0F: begin
                w_gpr_we    = 1'b1;
                w_gpr_wdata = {w_imm, 16'h0000};
            end
            6'h23: begin
                w_gpr_we    = 1'b1;
                w_gpr_wdata = r_dmem[w_mem_idx];
            end
            6'h2B: w_mem_we = 1'b1;
`ifdef HAHAHA_MADD_EN
            6'h1C: begin
                w_hilo_we   = 1'b1;
                w_hilo_next = {r_hi, r_lo} + w_prod_s;
            end
            6'h1D: begin
                w_hilo_we   = 1'b1;
                w_hilo_next = {r_hi, r_lo} + w_prod_u;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= (GPR_INIT_INDEX == 1) ? 32'(i) : 32'h0;
            end
            for (int j = 0; j < DMEM_WORDS; j++) begin
                r_dmem[j] <= 32'h0;
            end
            r_hi <= 32'h0;
            r_lo <= 32'h0;
        end else begin
            // GPR[0] is never written so it stays at its reset value of zero.
            if (w_gpr_we && (w_gpr_waddr != 5'd0)) begin
                r_gpr[w_gpr_waddr] <= w_gpr_wdata;
            end
            if (w_hilo_we) begin
                r_hi <= w_hilo_next[63:32];
                r_lo <= w_hilo_next[31:0];
            end
            if (w_mem_we) begin
                r_dmem[w_mem_idx] <= w_rt_val;
            end
        end
    end

    assign dbg_data = (dbg_addr == 5'd0) ? 32'h0 : r_gpr[dbg_addr];
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_hahaha.sv
// tb/tb_hahaha.sv - scoreboard testbench for the hahaha execute core
module tb_hahaha;
    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] hi;
    logic [31:0] lo;

    localparam logic [31:0] NOP = 32'hFC00_0000;

    int checks   = 0;
    int failures = 0;

    int          q_kind [$];
    logic [4:0]  q_addr [$];
    logic [31:0] q_exp  [$];
    string       q_tag  [$];

    hahaha dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // kind: 0 = GPR via debug port, 1 = HI, 2 = LO
    task automatic push_exp(input string tag, input int kind, input logic [4:0] addr, input logic [31:0] exp);
        q_tag.push_back(tag);
        q_kind.push_back(kind);
        q_addr.push_back(addr);
        q_exp.push_back(exp);
    endtask

    task automatic drain();
        string       t;
        int          k;
        logic [4:0]  a;
        logic [31:0] e;
        while (q_exp.size() > 0) begin
            t = q_tag.pop_front();
            k = q_kind.pop_front();
            a = q_addr.pop_front();
            e = q_exp.pop_front();
            dbg_addr = a;
            #1;
            if (k == 0)      check_eq(t, dbg_data, e);
            else if (k == 1) check_eq(t, hi, e);
            else             check_eq(t, lo, e);
        end
    endtask

    task automatic exec(input logic [31:0] instr, input int n);
        @(negedge clk);
        instruction = instr;
        repeat (n) @(posedge clk);
        @(negedge clk);
        instruction = NOP;
    endtask

    initial begin
        rst         = 1'b1;
        instruction = NOP;
        dbg_addr    = 5'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        push_exp("rst_gpr1", 0, 5'd1, 32'd1);
        push_exp("rst_gpr2", 0, 5'd2, 32'd2);
        push_exp("rst_gpr3", 0, 5'd3, 32'd3);
        push_exp("rst_gpr0", 0, 5'd0, 32'd0);
        push_exp("rst_hi",   1, 5'd0, 32'd0);
        push_exp("rst_lo",   2, 5'd0, 32'd0);
        drain();

        exec(32'h0022_1820, 2);
        push_exp("add_gpr3", 0, 5'd3, 32'd3);
        push_exp("add_gpr1", 0, 5'd1, 32'd1);
        push_exp("add_gpr2", 0, 5'd2, 32'd2);
        drain();

        exec(32'h0062_0018, 1);
        push_exp("mult_lo", 2, 5'd0, 32'd6);
        push_exp("mult_hi", 1, 5'd0, 32'd0);
        drain();

`ifdef HAHAHA_MADD_EN
        exec(32'h7462_0000, 1);
        push_exp("maddu1_lo", 2, 5'd0, 32'd12);
        drain();
        exec(32'h7462_0000, 2);
        push_exp("maddu3_lo", 2, 5'd0, 32'd24);
        push_exp("maddu3_hi", 1, 5'd0, 32'd0);
        drain();
`else
        exec(32'h7462_0000, 3);
        push_exp("maddu_nop_lo", 2, 5'd0, 32'd6);
        push_exp("maddu_nop_hi", 1, 5'd0, 32'd0);
        drain();
`endif

        exec(32'h2004_FFFF, 1);
        push_exp("addi_gpr4", 0, 5'd4, 32'hFFFF_FFFF);
        drain();
        exec(32'h0082_0018, 1);
        push_exp("mult_neg_hi", 1, 5'd0, 32'hFFFF_FFFF);
        push_exp("mult_neg_lo", 2, 5'd0, 32'hFFFF_FFFE);
        drain();
        exec(32'h0082_0019, 1);
        push_exp("multu_hi", 1, 5'd0, 32'h0000_0001);
        push_exp("multu_lo", 2, 5'd0, 32'hFFFF_FFFE);
        drain();
        exec(32'h0000_6012, 1);
        push_exp("mflo_gpr12", 0, 5'd12, 32'hFFFF_FFFE);
        drain();

        exec(32'h3C0B_03E8, 1);
        push_exp("lui_gpr11", 0, 5'd11, 32'h03E8_0000);
        drain();
        exec(32'hAC0B_0008, 1);
        exec(32'h8C0E_0008, 1);
        exec(32'h8C0F_0408, 1);
        exec(32'h8C10_000B, 1);
        push_exp("lw_gpr14",      0, 5'd14, 32'h03E8_0000);
        push_exp("lw_wrap_gpr15", 0, 5'd15, 32'h03E8_0000);
        push_exp("lw_low2_gpr16", 0, 5'd16, 32'h03E8_0000);
        drain();

        exec(32'h0022_0020, 1);
        push_exp("add_rd0", 0, 5'd0, 32'd0);
        drain();

        exec(32'h0022_2822, 1);
        exec(32'h00A1_302A, 1);
        exec(32'h00A1_382B, 1);
        exec(32'h0005_4103, 1);
        exec(32'h0005_4902, 1);
        exec(32'h340A_8001, 1);
        push_exp("sub_gpr5",  0, 5'd5,  32'hFFFF_FFFF);
        push_exp("slt_gpr6",  0, 5'd6,  32'd1);
        push_exp("sltu_gpr7", 0, 5'd7,  32'd0);
        push_exp("sra_gpr8",  0, 5'd8,  32'hFFFF_FFFF);
        push_exp("srl_gpr9",  0, 5'd9,  32'h0FFF_FFFF);
        push_exp("ori_gpr10", 0, 5'd10, 32'h0000_8001);
        drain();

        exec(32'h0022_0821, 2);
        push_exp("addu_accum_gpr1", 0, 5'd1, 32'd5);
        drain();

        exec(NOP, 3);
        push_exp("nop_gpr1", 0, 5'd1, 32'd5);
        push_exp("nop_lo",   2, 5'd0, 32'hFFFF_FFFE);
        drain();

        // Reset raised between edges must take effect without a clock edge.
        @(negedge clk);
        instruction = 32'h0022_0821;
        #2;
        rst = 1'b1;
        push_exp("arst_gpr1",  0, 5'd1,  32'd1);
        push_exp("arst_gpr11", 0, 5'd11, 32'd11);
        push_exp("arst_hi",    1, 5'd0,  32'd0);
        push_exp("arst_lo",    2, 5'd0,  32'd0);
        drain();
        instruction = NOP;
        @(negedge clk);
        rst = 1'b0;
        exec(32'h8C0E_0008, 1);
        push_exp("arst_dmem_gpr14", 0, 5'd14, 32'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hahaha.md
Name: hahaha

Overview:
- Single-cycle mini-MIPS execute core.
- Takes one 32-bit instruction word per clock from an external driver.
- Holds a 32x32 GPR file, HI/LO multiply registers and a small word-addressed data memory.
- Sits under the instruction-feed wrapper; exposes a debug read port for verification.

Parameters:
- DMEM_WORDS, 256, number of 32-bit data-memory words (index = address[log2(DMEM_WORDS)+1:2]).
- GPR_INIT_INDEX, 1, when 1, reset loads GPR[i]=i (i=1..31); when 0, reset loads all GPRs to 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- instruction  input  32  instruction executed on every rising clk edge.
- dbg_addr  input  5  GPR index for debug read.
- dbg_data  output  32  combinational GPR[dbg_addr]; 0 when dbg_addr=0.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async assert, sync-free release):
  - GPR[i]=i when GPR_INIT_INDEX=1, else 0.
  - hi=lo=0; all DMEM words=0.
  - Reset asserted mid-cycle overrides any write on that edge.
- Execution:
  - Every rising edge with rst=0 fully executes the current instruction; results are visible after that edge (latency 1).
  - No handshake and no PC: an instruction held N cycles executes N times, so accumulating ops accumulate N times.
- GPR[0] reads 0 always; writes to it are discarded.
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sh=[10:6], fn=[5:0], imm=[15:0].
- R-type (op 0x00), result to rd:
  - 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu: 32-bit wrap, no overflow trap.
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor.
  - 0x2A slt (signed), 0x2B sltu.
  - 0x00 sll rt<<sh, 0x02 srl, 0x03 sra.
  - 0x10 mfhi, 0x12 mflo.
- R-type HI/LO ops:
  - 0x18 mult: signed {hi,lo}=rs*rt (64-bit).
  - 0x19 multu: unsigned {hi,lo}=rs*rt (64-bit).
- I-type, result to rt:
  - 0x08 addi, 0x09 addiu: sign-extended imm, wrap.
  - 0x0A slti: signed compare with sign-extended imm.
  - 0x0C andi, 0x0D ori, 0x0E xori: zero-extended imm.
  - 0x0F lui: rt={imm,16'h0}.
- Memory, address=rs+signext(imm):
  - 0x23 lw: rt=DMEM[address[..:2]].
  - 0x2B sw: DMEM[address[..:2]]=rt.
  - Low 2 address bits ignored; out-of-range index wraps modulo DMEM_WORDS.
- Any unlisted op/fn is a NOP: no state change.
- All operands are read before the edge, so rd==rs is legal (old value used).

Optional Feature:
- Macro HAHAHA_MADD_EN.
- Defined:
  - op 0x1C madd: signed {hi,lo}+=rs*rt.
  - op 0x1D maddu: unsigned {hi,lo}+=rs*rt.
  - 64-bit accumulate, wrap modulo 2^64; other fields ignored.
- Undefined: ops 0x1C/0x1D are NOPs.

Test Plan:
- Reset with GPR_INIT_INDEX=1 -> dbg_data for addr 1,2,3 = 1,2,3; addr 0 = 0; hi=lo=0.
- add rd=3,rs=1,rt=2 (32'h00221820) held 2 cycles -> GPR[3]=3 (idempotent); GPR[1]=1, GPR[2]=2 unchanged.
- Then mult rs=3,rt=2 (32'h00620018) -> lo=6, hi=0. Then GPR[4]=32'hFFFFFFFF (via addi from GPR[0]) and mult with GPR[2] -> {hi,lo}=64'hFFFFFFFF_FFFFFFFE.
- With HAHAHA_MADD_EN, after lo=6/hi=0, maddu rs=3,rt=2 (32'h74620000):
  - held 1 cycle -> lo=12;
  - held 3 cycles total -> lo=24.
- Without the macro, the same word leaves lo=6.
- lui rt=11 imm=1000 -> GPR[11]=32'h03E80000. Then sw rt=11 at rs=0 imm=8, lw rt=14 rs=0 imm=8 -> GPR[14]=32'h03E80000.
- add targeting rd=0 -> GPR[0] still 0.
- Assert rst between edges mid-sequence -> all state returns to reset values immediately.
